// File: rtl/mem_responder.sv
// mem_responder
//   Single-port word memory that answers one request at a time with a fixed
//   response latency. A request is latched in IDLE, waits in BUSY, and is
//   served from RESP: the edge that leaves RESP performs the array access,
//   registers resp_data and raises response_enable for one cycle.
//
// Ports
//   clk             in   clock, rising edge
//   rstn            in   asynchronous active-low reset
//   request_enable  in   request strobe
//   req_mode        in   0 = read, 1 = write
//   req_addr        in   byte address (bits [1:0] ignored)
//   req_wdata       in   write data
//   req_wstrb       in   byte enables for req_wdata
//   response_enable out  one-cycle completion pulse
//   resp_data       out  read data / pre-write word, held between responses
//   access_fault    out  one-cycle pulse with response_enable for bad address
//   overrun         out  sticky: request seen while not IDLE
module mem_responder #(
    parameter int unsigned WORDS   = 4096,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        request_enable,
    input  logic        req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        response_enable,
    output logic [31:0] resp_data,
    output logic        access_fault,
    output logic        overrun
);

    localparam int unsigned AW = $clog2(WORDS);
    // Counter only has to hold LATENCY-2.
    localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_next;

    logic           r_mode;
    logic [31:2]    r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_wstrb;

    logic           r_resp_en;
    logic           r_fault;
    logic           r_overrun;
    logic [31:0]    r_rdata;

    logic [31:0]    r_mem [0:WORDS-1];

    logic           w_accept;
    logic           w_serve;
    logic           w_in_range;
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_old;
    logic [1:0]     w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = req_addr[1:0];

    assign w_accept   = (r_state == IDLE) && request_enable;
    assign w_serve    = (r_state == RESP);
    assign w_in_range = ({2'b00, r_addr} < 32'(WORDS));
    assign w_idx      = r_addr[AW+1:2];
    assign w_old      = r_mem[w_idx];

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (request_enable) begin
                    if (LATENCY == 1) begin
                        w_next = RESP;
                    end else begin
                        w_next     = BUSY;
                        w_cnt_next = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_resp_en <= 1'b0;
            r_fault   <= 1'b0;
            r_overrun <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            if (w_accept) begin
                r_mode  <= req_mode;
                r_addr  <= req_addr[31:2];
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
            end
            // The pulse is produced on the edge that leaves RESP, so it lands
            // LATENCY edges after the accepting edge.
            r_resp_en <= w_serve;
            r_fault   <= w_serve && !w_in_range;
            if (request_enable && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_serve) begin
                r_rdata <= w_in_range ? w_old : '0;
            end
        end
    end

    // Array is deliberately outside the reset domain; reset forces IDLE so
    // an aborted transaction never reaches the write below.
    always_ff @(posedge clk) begin
        if (w_serve && r_mode && w_in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign response_enable = r_resp_en;
    assign resp_data       = r_rdata;
    assign access_fault    = r_fault;
    assign overrun         = r_overrun;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WORDS, default 4096, number of 32-bit words in the backing array (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, default 2, edges from request sample to response assertion (integer >=1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port request_enable  input  1  request strobe from the initiator, sampled on clk.
REQ-006 SHALL have port req_mode  input  1  0 = MEMREQ_READ, 1 = MEMREQ_WRITE.
REQ-007 SHALL have port req_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port req_wdata  input  32  write data.
REQ-009 SHALL have port req_wstrb  input  4  byte enables; bit n covers wdata[8n+7:8n].
REQ-010 SHALL have port response_enable  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_data  output  32  read data, or pre-write word for writes.
REQ-012 SHALL have port access_fault  output  1  one-cycle pulse, coincident with response_enable, for out-of-range address.
REQ-013 SHALL have port overrun  output  1  sticky flag: request_enable seen while not IDLE.

Function
REQ-014 SHALL implement states IDLE, BUSY, RESP.
REQ-015 In IDLE, request_enable=1 at edge k SHALL latch mode, addr, wdata, wstrb and leave IDLE (to RESP if LATENCY=1, else to BUSY).
REQ-016 In IDLE, request_enable=0 SHALL hold all state.
REQ-017 BUSY SHALL use a down-counter loaded with LATENCY-2 on entry, moving to RESP on the edge where it is 0, otherwise decrementing.
REQ-018 response_enable SHALL go 1 at edge k+LATENCY and return to 0 at edge k+LATENCY+1, i.e. high for exactly one cycle.
REQ-019 RESP SHALL return to IDLE unconditionally at the next edge; a request presented in the cycle after response_enable SHALL be accepted.
REQ-020 Word index SHALL be addr[log2(WORDS)+1:2]; the address is in range iff addr[31:2] < WORDS.
REQ-021 Read in range: resp_data SHALL equal the array word at the index, valid while response_enable=1.
REQ-022 Write in range: resp_data SHALL be the word before the write; array bytes with wstrb=1 SHALL be updated on the edge that asserts response_enable; bytes with wstrb=0 unchanged.
REQ-023 Write with wstrb=4'b0000 SHALL complete normally with no array change.
REQ-024 Out-of-range: resp_data SHALL be 32'h0, no array change, access_fault=1 for the response cycle.
REQ-025 request_enable=1 in BUSY or RESP SHALL be ignored (no latch, no timing change) and SHALL set overrun=1, cleared only by reset.
REQ-026 Latched request fields SHALL NOT change between acceptance and response, regardless of input activity.
REQ-027 resp_data SHALL hold its last value outside response cycles.
REQ-028 Read-after-write to the same word, issued in the cycle after the write response, SHALL return the written data.

Reset
REQ-029 rstn=0 SHALL immediately force state=IDLE, response_enable=0, access_fault=0, overrun=0, resp_data=32'h0, counter=0, latched fields=0.
REQ-030 Reset mid-transaction SHALL abort it with no response pulse and no array write; array contents are not cleared.
REQ-031 First request SHALL be accepted at the first rising edge with rstn=1.

Verification
REQ-032 LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF at edge 5 -> response_enable high only after edge 7; read 0x10 at edge 8 -> resp_data 0xDEADBEEF after edge 10.
REQ-033 Byte strobe: word 0x10 = 0xDEADBEEF, write 0x11223344 with wstrb 4'b0101 -> resp_data 0xDEADBEEF; later read returns 0xDE22BE44.
REQ-034 Out-of-range: WORDS=4096, read 0x00004000 -> resp_data 0, access_fault and response_enable high together for one cycle; overrun stays 0.
REQ-035 Overrun: request at edge 5, second request at edge 6 -> single response after edge 7 for the first request only; overrun=1 from edge 6 until reset.
REQ-036 Reset abort: write 0x20 accepted at edge 5, rstn low between edges 6 and 7 -> no response pulse, outputs 0; read 0x20 afterwards returns prior contents.
REQ-037 LATENCY=1 back-to-back: requests at edges 3 and 5 -> responses after edges 4 and 6, overrun=0.
